// File: rtl/pdm_pcm_frontend.sv
// PDM clock generator, 2-flop bit capture and per-mic 3rd-order CIC decimator.
// Optional macro PCM_CLIP_DETECT_EN adds a per-channel pcm_clip output.
module pdm_pcm_frontend #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_MICS   = 9,
  parameter int CLK_DIV    = 25,
  parameter int LOG2_DECIM = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_MICS-1:0]  pdm_data_in,
  output logic                 pdm_clk_out,
  output logic [BIT_WIDTH-1:0] pcm_data_out [0:NUM_MICS-1],
`ifdef PCM_CLIP_DETECT_EN
  output logic [NUM_MICS-1:0]  pcm_clip,
`endif
  output logic                 pcm_valid
);

  localparam int W  = 3*LOG2_DECIM+1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV-1);
  localparam logic [BIT_WIDTH-1:0] MID = BIT_WIDTH'(1) << (BIT_WIDTH-1);
  localparam logic [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0] TOP_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};

  logic [NUM_MICS-1:0]   r_sync1;
  logic [NUM_MICS-1:0]   r_sync2;
  logic [DW-1:0]         r_div;
  logic                  r_pdm_clk;
  logic [LOG2_DECIM-1:0] r_dec;
  logic [1:0]            r_warm;
  logic                  r_valid;

  logic [W-1:0] r_int1 [NUM_MICS];
  logic [W-1:0] r_int2 [NUM_MICS];
  logic [W-1:0] r_int3 [NUM_MICS];
  logic [W-1:0] r_dly1 [NUM_MICS];
  logic [W-1:0] r_dly2 [NUM_MICS];
  logic [W-1:0] r_dly3 [NUM_MICS];
  logic [BIT_WIDTH-1:0] r_pcm [NUM_MICS];

  logic w_strobe;
  logic w_block;
  logic w_emit;

  logic [W-1:0] w_x  [NUM_MICS];
  logic [W-1:0] w_i1 [NUM_MICS];
  logic [W-1:0] w_i2 [NUM_MICS];
  logic [W-1:0] w_i3 [NUM_MICS];
  logic [W-1:0] w_c1 [NUM_MICS];
  logic [W-1:0] w_c2 [NUM_MICS];
  logic [W-1:0] w_c3 [NUM_MICS];
  logic         w_edge [NUM_MICS];
  logic [BIT_WIDTH-1:0] w_top [NUM_MICS];
  logic [BIT_WIDTH-1:0] w_pcm [NUM_MICS];

  assign w_strobe = enable && (r_div == DIV_LAST) && r_pdm_clk;
  assign w_block  = w_strobe && (&r_dec);
  assign w_emit   = w_block && (r_warm == 2'd3);

  // +FS and -FS share one W-bit pattern; the newest bit tells them apart.
  always_comb begin
    for (int m = 0; m < NUM_MICS; m++) begin
      w_x[m]    = r_sync2[m] ? W'(1) : '1;
      w_i1[m]   = r_int1[m] + w_x[m];
      w_i2[m]   = r_int2[m] + w_i1[m];
      w_i3[m]   = r_int3[m] + w_i2[m];
      w_c1[m]   = w_i3[m] - r_dly1[m];
      w_c2[m]   = w_c1[m] - r_dly2[m];
      w_c3[m]   = w_c2[m] - r_dly3[m];
      w_edge[m] = (w_c3[m] == W_MIN);
      w_top[m]  = w_c3[m][W-1 -: BIT_WIDTH];
      if (w_edge[m] && r_sync2[m]) begin
        w_top[m] = TOP_MAX;
      end
      w_pcm[m]  = {~w_top[m][BIT_WIDTH-1], w_top[m][BIT_WIDTH-2:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pdm_data_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_pdm_clk <= 1'b0;
      r_dec     <= '0;
      r_warm    <= 2'd0;
      r_valid   <= 1'b0;
    end else if (!enable) begin
      r_div     <= '0;
      r_pdm_clk <= 1'b0;
      r_dec     <= '0;
      r_warm    <= 2'd0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_emit;
      if (r_div == DIV_LAST) begin
        r_div     <= '0;
        r_pdm_clk <= ~r_pdm_clk;
      end else begin
        r_div <= r_div + DW'(1);
      end
      if (w_strobe) begin
        r_dec <= r_dec + LOG2_DECIM'(1);
      end
      if (w_block && (r_warm != 2'd3)) begin
        r_warm <= r_warm + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < NUM_MICS; m++) begin
        r_int1[m] <= '0;
        r_int2[m] <= '0;
        r_int3[m] <= '0;
        r_dly1[m] <= '0;
        r_dly2[m] <= '0;
        r_dly3[m] <= '0;
        r_pcm[m]  <= MID;
      end
    end else begin
      for (int m = 0; m < NUM_MICS; m++) begin
        if (!enable) begin
          r_int1[m] <= '0;
          r_int2[m] <= '0;
          r_int3[m] <= '0;
          r_dly1[m] <= '0;
          r_dly2[m] <= '0;
          r_dly3[m] <= '0;
        end else begin
          if (w_strobe) begin
            r_int1[m] <= w_i1[m];
            r_int2[m] <= w_i2[m];
            r_int3[m] <= w_i3[m];
          end
          if (w_block) begin
            r_dly1[m] <= w_i3[m];
            r_dly2[m] <= w_c1[m];
            r_dly3[m] <= w_c2[m];
          end
        end
        if (w_emit) begin
          r_pcm[m] <= w_pcm[m];
        end
      end
    end
  end

`ifdef PCM_CLIP_DETECT_EN
  logic [NUM_MICS-1:0] r_clip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clip <= '0;
    end else if (w_emit) begin
      for (int m = 0; m < NUM_MICS; m++) begin
        r_clip[m] <= w_edge[m];
      end
    end
  end

  assign pcm_clip = r_clip;
`endif

  assign pdm_clk_out  = r_pdm_clk;
  assign pcm_valid    = r_valid;
  assign pcm_data_out = r_pcm;

endmodule

// File: tb/tb_pdm_pcm_frontend.sv
// Directed bench for pdm_pcm_frontend: divider, CIC levels, warm-up,
// enable drop, async reset and integrator wrap on a short-decimation copy.
module tb_pdm_pcm_frontend;

  localparam logic [71:0] ALL_FF = {9{8'hff}};
  localparam logic [71:0] ALL_80 = {9{8'h80}};
  localparam logic [71:0] MIXED  = 72'hffff_ffff_ff40_80c0_00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [8:0] pdm_data;
  logic       pdm_clk;
  logic [7:0] pcm [0:8];
  logic       pcm_valid;

  logic       rst2_n;
  logic       en2;
  logic       pdm_clk2;
  logic [7:0] pcm2 [0:0];
  logic       pcm_valid2;

`ifdef PCM_CLIP_DETECT_EN
  logic [8:0] clip;
  logic [0:0] clip2;
`endif

  logic [3:0] pat [9];
  logic [1:0] ph = 2'd0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pdm_pcm_frontend #(
    .BIT_WIDTH(8), .NUM_MICS(9), .CLK_DIV(4), .LOG2_DECIM(6)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(en),
    .pdm_data_in(pdm_data),
    .pdm_clk_out(pdm_clk),
    .pcm_data_out(pcm),
`ifdef PCM_CLIP_DETECT_EN
    .pcm_clip(clip),
`endif
    .pcm_valid(pcm_valid)
  );

  pdm_pcm_frontend #(
    .BIT_WIDTH(8), .NUM_MICS(1), .CLK_DIV(4), .LOG2_DECIM(3)
  ) u_wrap (
    .clk(clk),
    .rst_n(rst2_n),
    .enable(en2),
    .pdm_data_in(1'b1),
    .pdm_clk_out(pdm_clk2),
    .pcm_data_out(pcm2),
`ifdef PCM_CLIP_DETECT_EN
    .pcm_clip(clip2),
`endif
    .pcm_valid(pcm_valid2)
  );

  // mics present a new bit on each rising PDM clock edge
  always @(posedge pdm_clk) ph = ph + 2'd1;

  always_comb begin
    for (int m = 0; m < 9; m++) begin
      pdm_data[m] = pat[m][ph];
    end
  end

  function automatic logic [71:0] pack9();
    logic [71:0] v;
    v = '0;
    for (int m = 0; m < 9; m++) begin
      v[m*8 +: 8] = pcm[m];
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input bit sel, input int start, input int limit,
                            output int n);
    n = start;
    while (n < limit) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if ((sel ? pcm_valid2 : pcm_valid) === 1'b1) break;
    end
  endtask

  initial begin
    logic [15:0] tr;
    int n;
    int bad;

    rst_n  = 1'b0;
    rst2_n = 1'b0;
    en     = 1'b0;
    en2    = 1'b0;
    for (int m = 0; m < 9; m++) pat[m] = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_pdm", 72'(pdm_clk), 72'd0);
    check("rst_valid", 72'(pcm_valid), 72'd0);
    check("rst_pcm", pack9(), ALL_80);
`ifdef PCM_CLIP_DETECT_EN
    check("rst_clip", 72'(clip), 72'd0);
`endif
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // divider: 4 low, 4 high, first rise CLK_DIV edges after enable
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      tr[i] = pdm_clk;
    end
    check("div_trace", 72'(tr), 72'h7878);

    // full scale: 4th block ends at strobe 256 = edge 2048
    wait_valid(1'b0, 16, 4000, n);
    check("fs_latency", 72'(n), 72'd2048);
    check("fs_pcm", pack9(), ALL_FF);
`ifdef PCM_CLIP_DETECT_EN
    check("fs_clip", 72'(clip), 72'h1ff);
`endif
    for (int k = 0; k < 3; k++) begin
      wait_valid(1'b0, 0, 1000, n);
      check("fs_gap", 72'(n), 72'd512);
      check("fs_pcm_next", pack9(), ALL_FF);
    end

    // asynchronous reset while pdm_clk high and pcm at full scale
    n = 0;
    while (pdm_clk !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_pdm", 72'(pdm_clk), 72'd0);
    check("arst_valid", 72'(pcm_valid), 72'd0);
    check("arst_pcm", pack9(), ALL_80);
`ifdef PCM_CLIP_DETECT_EN
    check("arst_clip", 72'(clip), 72'd0);
`endif

    // mixed densities: 0, 3/4, 1/2, 1/4, then full scale
    en = 1'b0;
    pat[0] = 4'b0000;
    pat[1] = 4'b0111;
    pat[2] = 4'b0101;
    pat[3] = 4'b0001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    wait_valid(1'b0, 0, 4000, n);
    check("mix_latency", 72'(n), 72'd2048);
    check("mix_pcm", pack9(), MIXED);
`ifdef PCM_CLIP_DETECT_EN
    check("mix_clip", 72'(clip), 72'h1f1);
`endif
    for (int k = 0; k < 3; k++) begin
      wait_valid(1'b0, 0, 1000, n);
      check("mix_gap", 72'(n), 72'd512);
      check("mix_pcm_next", pack9(), MIXED);
    end

    // enable drop mid-block
    repeat (100) @(negedge clk);
    en  = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (pdm_clk !== 1'b0 || pcm_valid !== 1'b0) bad++;
    end
    check("dis_quiet", 72'(bad), 72'd0);
    check("dis_hold", pack9(), MIXED);
    en = 1'b1;
    wait_valid(1'b0, 0, 4000, n);
    check("reen_latency", 72'(n), 72'd2048);
    check("reen_pcm", pack9(), MIXED);

    // wrap: decimation 8 (W=10), run past 2^10 strobes of constant 1
    @(negedge clk);
    en  = 1'b0;
    en2 = 1'b1;
    wait_valid(1'b1, 0, 1000, n);
    check("wrap_latency", 72'(n), 72'd256);
    check("wrap_pcm_first", 72'(pcm2[0]), 72'hff);
    bad = 0;
    for (int k = 0; k < 130; k++) begin
      wait_valid(1'b1, 0, 200, n);
      if (n != 64 || pcm2[0] !== 8'hff) bad++;
    end
    check("wrap_steady", 72'(bad), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pdm_pcm_frontend.md
Name: pdm_pcm_frontend

Overview:
- Multi-channel PDM microphone front end: generates the shared PDM bit clock, captures one PDM bit per mic, and decimates each channel to BIT_WIDTH-bit offset-binary PCM with a 3rd-order CIC filter.
- Produces the per-mic PCM array consumed by the delay-and-sum beamformer. Midscale is 128 for BIT_WIDTH=8.
- All channels share one clock divider and one decimation counter, so the outputs are sample-aligned.

Parameters:
- BIT_WIDTH, 8: PCM output width.
- NUM_MICS, 9: number of PDM data lines / PCM channels.
- CLK_DIV, 25: clk cycles per PDM clock half-period; legal range ≥4.
- LOG2_DECIM, 6: decimation ratio is 2^LOG2_DECIM. Derived CIC width W = 3*LOG2_DECIM+1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: synchronous run enable.
- pdm_data_in, input, [NUM_MICS-1:0]: one PDM bit per mic, asynchronous to clk.
- pdm_clk_out, output, 1: PDM bit clock to the mics, registered.
- pcm_data_out, output, [BIT_WIDTH-1:0] x NUM_MICS (unpacked array [0:NUM_MICS-1]): offset-binary PCM per mic.
- pcm_valid, output, 1: one-cycle strobe; all pcm_data_out entries are new.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous, active-low on rst_n.
- Reset values:
  - pdm_clk_out=0, pcm_valid=0.
  - Every pcm_data_out = 2^(BIT_WIDTH-1).
  - Divider, decimation counter, warm-up counter, integrators, comb delays and synchronizers all 0.
- Input synchronizer: pdm_data_in passes through a 2-flop synchronizer per bit.
- Clock divider:
  - Counter runs 0..CLK_DIV-1; at CLK_DIV-1 it wraps and toggles pdm_clk_out.
  - Period is 2*CLK_DIV clk cycles, 50% duty.
  - sample_strobe asserts on the cycle pdm_clk_out toggles 1→0. The synchronized bit present in that cycle is the sample.
- Integrators, on each sample_strobe:
  - Bit maps 1→+1, 0→-1.
  - Three cascaded two's-complement integrators, W bits, wrap modulo 2^W (intentional, no saturation).
- Decimation counter:
  - Counts strobes 0..2^LOG2_DECIM-1.
  - The strobe at the terminal count completes a block; the counter then wraps.
- Combs, on each block completion: three cascaded differentiators with differential delay 1, W bits, wrapping. The result is in [-2^(W-1), +2^(W-1)].
- Output conversion:
  - Saturate +2^(W-1) to 2^(W-1)-1.
  - Take bits [W-1:W-BIT_WIDTH] and invert the MSB to get offset binary.
  - All-ones input → 255; all-zeros → 0; 50% density → 128.
- Latency: pcm_data_out and pcm_valid update on the clk edge following the completing strobe's cycle. Data holds until the next valid.
- Warm-up: the first 3 completed blocks after reset or enable rising produce no pcm_valid, and pcm_data_out is not updated. The 4th block is the first valid output.
- enable=0:
  - pdm_clk_out forced 0.
  - Divider, decimation, warm-up, integrators and combs cleared.
  - pcm_valid=0; pcm_data_out holds its last value.
  - Deassertion mid-block discards the partial block.
- enable rising: the divider restarts from 0. The first toggle (0→1) occurs CLK_DIV cycles later.
- Simultaneous events: if enable falls in the same cycle as a completing strobe, enable wins and no valid is produced.

Optional Feature:
- Macro: PCM_CLIP_DETECT_EN.
- Defined: adds output pcm_clip [NUM_MICS-1:0].
  - Bit k = 1 when channel k's comb result hit the positive saturation or equalled -2^(W-1).
  - Updated with pcm_valid and held between valids; reset value 0.
- Undefined: port absent. Saturation is still performed.

Test Plan:
- Reset: assert rst_n=0 mid-run → pdm_clk_out=0, pcm_valid=0, all pcm_data_out=128 immediately (asynchronous).
- Divider: CLK_DIV=4, enable=1 → pdm_clk_out period 8 clk, high 4 / low 4; sample_strobe once per period.
- Full scale: all mics constant 1, LOG2_DECIM=6 → first pcm_valid after 256 strobes, every channel 255. With PCM_CLIP_DETECT_EN, pcm_clip=all ones.
- Mixed density: mic0 constant 0, mic1 pattern 1110 repeating, mic2 alternating 10 → after warm-up mic0=0, mic1=192, mic2=128, steady on every subsequent valid.
- Enable drop: deassert enable for 10 clk mid-block after several valids, then reassert →
  - pdm_clk_out low while disabled.
  - pcm_data_out holds its old value.
  - No pcm_valid until 4 full blocks after re-enable.
- Wrap: run constant-1 input for ≥2^W strobes → integrator wrap has no effect; every output stays 255.
